// File: rtl/data_mem.sv
// Data-memory responder for the MEM stage: word RAM with byte/half/word access,
// same-cycle load data, and an MMIO page (console, 64-bit cycle counter, status).
module data_mem #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] MEM_mem_addr,
  input  logic [3:0]  MEM_mem_cmd,
  input  logic [31:0] MEM_mem_din,
  output logic [31:0] DM_mem_dout,
  output logic [7:0]  DM_con_data,
  output logic        DM_con_vld,
  output logic        DM_misalign
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  localparam logic [3:0] MEM_NONE = 4'd0;
  localparam logic [3:0] MEM_LB   = 4'd1;
  localparam logic [3:0] MEM_LH   = 4'd2;
  localparam logic [3:0] MEM_LW   = 4'd3;
  localparam logic [3:0] MEM_LBU  = 4'd4;
  localparam logic [3:0] MEM_LHU  = 4'd5;
  localparam logic [3:0] MEM_SB   = 4'd6;
  localparam logic [3:0] MEM_SH   = 4'd7;
  localparam logic [3:0] MEM_SW   = 4'd8;

  localparam logic [1:0] REG_CONSOLE = 2'd0;
  localparam logic [1:0] REG_CYC_LO  = 2'd1;
  localparam logic [1:0] REG_CYC_HI  = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  logic [31:0] mem [DEPTH_WORDS];

  logic [63:0] cyc_cnt;
  logic [31:0] cyc_hi_shadow;

  logic        is_load, is_store, is_byte, is_half, is_word, is_signed;
  logic        misaligned, access_ok;
  logic        is_mmio, in_page;
  logic [29:0] mmio_word;
  logic [1:0]  mmio_reg;
  logic [AW-1:0] ram_idx;
  logic [31:0] rd_word;
  logic [31:0] load_val;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic        ram_we, con_we, status_w1c, shadow_we;

  assign ram_idx   = MEM_mem_addr[AW+1:2];
  assign is_mmio   = (MEM_mem_addr >= MMIO_BASE);
  assign mmio_word = 30'((MEM_mem_addr - MMIO_BASE) >> 2);
  assign in_page   = (mmio_word[29:2] == 28'd0);
  assign mmio_reg  = mmio_word[1:0];

  // Command decode, alignment check and write-side controls
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_byte   = 1'b0;
    is_half   = 1'b0;
    is_word   = 1'b0;
    is_signed = 1'b0;
    unique case (MEM_mem_cmd)
      MEM_LB:  begin is_load  = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
      MEM_LH:  begin is_load  = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
      MEM_LW:  begin is_load  = 1'b1; is_word = 1'b1; end
      MEM_LBU: begin is_load  = 1'b1; is_byte = 1'b1; end
      MEM_LHU: begin is_load  = 1'b1; is_half = 1'b1; end
      MEM_SB:  begin is_store = 1'b1; is_byte = 1'b1; end
      MEM_SH:  begin is_store = 1'b1; is_half = 1'b1; end
      MEM_SW:  begin is_store = 1'b1; is_word = 1'b1; end
      default: ;
    endcase

    misaligned = (is_half && MEM_mem_addr[0]) ||
                 (is_word && (MEM_mem_addr[1:0] != 2'b00));
    access_ok  = (is_load || is_store) && !misaligned;

    ram_be    = 4'b0000;
    ram_wdata = MEM_mem_din;
    if (is_byte) begin
      ram_be    = 4'(4'b0001 << MEM_mem_addr[1:0]);
      ram_wdata = {4{MEM_mem_din[7:0]}};
    end else if (is_half) begin
      ram_be    = MEM_mem_addr[1] ? 4'b1100 : 4'b0011;
      ram_wdata = {2{MEM_mem_din[15:0]}};
    end else if (is_word) begin
      ram_be    = 4'b1111;
    end

    // MMIO registers only accept writes at their word address
    ram_we     = access_ok && is_store && !is_mmio;
    con_we     = access_ok && is_mmio && in_page && (mmio_reg == REG_CONSOLE) &&
                 (MEM_mem_addr[1:0] == 2'b00) &&
                 ((MEM_mem_cmd == MEM_SB) || (MEM_mem_cmd == MEM_SW));
    status_w1c = access_ok && is_mmio && in_page && (mmio_reg == REG_STATUS) &&
                 (MEM_mem_addr[1:0] == 2'b00) && MEM_mem_din[0] &&
                 ((MEM_mem_cmd == MEM_SB) || (MEM_mem_cmd == MEM_SW));
    shadow_we  = access_ok && is_mmio && in_page && (mmio_reg == REG_CYC_LO) &&
                 (MEM_mem_cmd == MEM_LW);
  end

  // Source word selection and load extraction/extension
  always_comb begin
    rd_word = 32'd0;
    if (is_mmio) begin
      if (in_page) begin
        unique case (mmio_reg)
          REG_CONSOLE: rd_word = 32'd0;
          REG_CYC_LO:  rd_word = cyc_cnt[31:0];
          REG_CYC_HI:  rd_word = cyc_hi_shadow;
          REG_STATUS:  rd_word = {31'd0, DM_misalign};
          default:     rd_word = 32'd0;
        endcase
      end
    end else begin
      rd_word = mem[ram_idx];
    end

    load_val = rd_word;
    if (is_byte) begin
      unique case (MEM_mem_addr[1:0])
        2'd0:    load_val = {{24{is_signed & rd_word[7]}},  rd_word[7:0]};
        2'd1:    load_val = {{24{is_signed & rd_word[15]}}, rd_word[15:8]};
        2'd2:    load_val = {{24{is_signed & rd_word[23]}}, rd_word[23:16]};
        default: load_val = {{24{is_signed & rd_word[31]}}, rd_word[31:24]};
      endcase
    end else if (is_half) begin
      load_val = MEM_mem_addr[1] ? {{16{is_signed & rd_word[31]}}, rd_word[31:16]}
                                 : {{16{is_signed & rd_word[15]}}, rd_word[15:0]};
    end

    DM_mem_dout = (access_ok && is_load) ? load_val : 32'd0;
  end

  // RAM byte-lane writes; stores are suppressed while reset is asserted
  always_ff @(posedge clk) begin
    if (rst_n && ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i]) mem[ram_idx][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
  end

  // Cycle counter, hi shadow, console port and sticky misalign flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt       <= 64'd0;
      cyc_hi_shadow <= 32'd0;
      DM_con_data   <= 8'd0;
      DM_con_vld    <= 1'b0;
      DM_misalign   <= 1'b0;
    end else begin
      cyc_cnt    <= cyc_cnt + 64'd1;
      DM_con_vld <= con_we;
      if (shadow_we) cyc_hi_shadow <= cyc_cnt[63:32];
      if (con_we)    DM_con_data   <= MEM_mem_din[7:0];
      if ((is_load || is_store) && misaligned) DM_misalign <= 1'b1;
      else if (status_w1c)                      DM_misalign <= 1'b0;
    end
  end

endmodule
